// File: rtl/multicycle_ctrl_if.sv
// Handshake and control bundle between the multi-cycle sequencer and the memories/datapath.
// master = sequencer side, slave = memory/datapath side.
interface multicycle_ctrl_if;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] instr;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;
  logic [3:0]  ALUop;
  logic        ALUsrc;
  logic        RUWr;
  logic        pc_we;
  logic        halt;
  logic        busy;

  modport master (
    output imem_req, dmem_req, dmem_we, ALUop, ALUsrc, RUWr, pc_we, halt, busy,
    input  imem_ack, instr, dmem_ack
  );

  modport slave (
    input  imem_req, dmem_req, dmem_we, ALUop, ALUsrc, RUWr, pc_we, halt, busy,
    output imem_ack, instr, dmem_ack
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB with memory timeouts and sticky HALT.
// Optional performance counters are built when MULTICYCLE_PERF_CNT_EN is defined.
module multicycle_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  multicycle_ctrl_if.master  bus
`ifdef MULTICYCLE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]   retired_cnt,
  output logic [CNT_W-1:0]   cycle_cnt
`endif
);

  localparam int unsigned WaitW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WaitW-1:0] WaitLim = WaitW'(TIMEOUT_CYC - 1);

  localparam logic [6:0] OpR     = 7'b0110011;
  localparam logic [6:0] OpIAlu  = 7'b0010011;
  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;

  typedef enum logic [2:0] {
    StIdle, StFetch, StDecode, StExec, StMem, StWb, StHalt
  } state_e;

  typedef enum logic [2:0] {
    ClsIll, ClsR, ClsI, ClsLoad, ClsStore
  } cls_e;

  state_e           state_q, state_d;
  logic [WaitW-1:0] wait_q, wait_d;
  // Only the decode fields {funct7, funct3, opcode} of the instruction are kept.
  logic [16:0]      ir_q, ir_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  cls_e       cls;
  logic [3:0] alu_op_dec;
  logic       alu_src_dec;

  logic       imem_req, dmem_req, dmem_we, ru_wr, pc_we, halt, busy, alu_src;
  logic [3:0] alu_op;

  assign opcode = ir_q[6:0];
  assign funct3 = ir_q[9:7];
  assign funct7 = ir_q[16:10];

  always_comb begin
    cls         = ClsIll;
    alu_op_dec  = 4'b0000;
    alu_src_dec = 1'b0;
    case (opcode)
      OpR: begin
        alu_op_dec = {funct7[5], funct3};
        if (funct7 == 7'b0000000 ||
            (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))) begin
          cls = ClsR;
        end
      end
      OpIAlu: begin
        alu_src_dec = 1'b1;
        alu_op_dec  = (funct3 == 3'b101) ? {funct7[5], 3'b101} : {1'b0, funct3};
        if (funct3 == 3'b001) begin
          if (funct7 == 7'b0000000) cls = ClsI;
        end else if (funct3 == 3'b101) begin
          if (funct7 == 7'b0000000 || funct7 == 7'b0100000) cls = ClsI;
        end else begin
          cls = ClsI;
        end
      end
      OpLoad: begin
        alu_src_dec = 1'b1;
        cls         = ClsLoad;
      end
      OpStore: begin
        alu_src_dec = 1'b1;
        cls         = ClsStore;
      end
      default: cls = ClsIll;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      wait_q  <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    wait_d   = '0;
    ir_d     = ir_q;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    ru_wr    = 1'b0;
    pc_we    = 1'b0;
    halt     = 1'b0;
    busy     = 1'b1;
    alu_op   = 4'b0000;
    alu_src  = 1'b0;
    unique case (state_q)
      StIdle: begin
        busy    = 1'b0;
        state_d = StFetch;
      end
      StFetch: begin
        imem_req = 1'b1;
        if (bus.imem_ack) begin
          ir_d    = {bus.instr[31:25], bus.instr[14:12], bus.instr[6:0]};
          state_d = StDecode;
        end else if (wait_q == WaitLim) begin
          state_d = StHalt;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StDecode: begin
        state_d = (cls == ClsIll) ? StHalt : StExec;
      end
      StExec: begin
        alu_op  = alu_op_dec;
        alu_src = alu_src_dec;
        state_d = (cls == ClsLoad || cls == ClsStore) ? StMem : StWb;
      end
      StMem: begin
        alu_op  = alu_op_dec;
        alu_src = alu_src_dec;
        // Request drops in the ack cycle so the store's pc_we never overlaps dmem_req.
        dmem_req = !bus.dmem_ack;
        dmem_we  = dmem_req && (cls == ClsStore);
        if (bus.dmem_ack) begin
          if (cls == ClsStore) begin
            pc_we   = 1'b1;
            state_d = StFetch;
          end else begin
            state_d = StWb;
          end
        end else if (wait_q == WaitLim) begin
          state_d = StHalt;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StWb: begin
        alu_op  = alu_op_dec;
        alu_src = alu_src_dec;
        ru_wr   = 1'b1;
        pc_we   = 1'b1;
        state_d = StFetch;
      end
      StHalt: begin
        busy = 1'b0;
        halt = 1'b1;
      end
      default: begin
        busy    = 1'b0;
        state_d = StHalt;
      end
    endcase
  end

  assign bus.imem_req = imem_req;
  assign bus.dmem_req = dmem_req;
  assign bus.dmem_we  = dmem_we;
  assign bus.ALUop    = alu_op;
  assign bus.ALUsrc   = alu_src;
  assign bus.RUWr     = ru_wr;
  assign bus.pc_we    = pc_we;
  assign bus.halt     = halt;
  assign bus.busy     = busy;

`ifdef MULTICYCLE_PERF_CNT_EN
  logic [CNT_W-1:0] retired_q, cycle_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_q <= '0;
      cycle_q   <= '0;
    end else begin
      if (pc_we) retired_q <= retired_q + 1'b1;
      if (state_q != StHalt) cycle_q <= cycle_q + 1'b1;
    end
  end

  assign retired_cnt = retired_q;
  assign cycle_cnt   = cycle_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: ALU/load/store sequencing, illegal decode, timeouts, reset.
module tb_multicycle_ctrl;

  localparam logic [31:0] InsAdd  = 32'h002081B3;
  localparam logic [31:0] InsSub  = 32'h402081B3;
  localparam logic [31:0] InsSra  = 32'h4020D1B3;
  localparam logic [31:0] InsSrai = 32'h4020D093;
  localparam logic [31:0] InsAndi = 32'h0FF0F093;
  localparam logic [31:0] InsLw   = 32'h00012083;
  localparam logic [31:0] InsSw   = 32'h00112023;
  localparam logic [31:0] InsIll  = 32'h0000007F;
  localparam logic [31:0] InsMul  = 32'h022081B3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_assert = 0;
  int   n_fail = 0;

  multicycle_ctrl_if bus ();

`ifdef MULTICYCLE_PERF_CNT_EN
  logic [31:0] retired_cnt, cycle_cnt;
`endif

  multicycle_ctrl #(
    .TIMEOUT_CYC(16),
    .CNT_W      (32)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
`ifdef MULTICYCLE_PERF_CNT_EN
    ,
    .retired_cnt(retired_cnt),
    .cycle_cnt  (cycle_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts in FETCH; leaves the DUT in DECODE with a garbage word on instr.
  task automatic do_fetch(input logic [31:0] w, input int waits);
    for (int i = 0; i < waits; i++) step();
    bus.imem_ack = 1'b1;
    bus.instr    = w;
    step();
    bus.imem_ack = 1'b0;
    bus.instr    = 32'hFFFF_FFFF;
  endtask

  task automatic run_alu(input string tag, input logic [31:0] w, input logic [3:0] op,
                         input logic src);
    do_fetch(w, 0);
    step();
    chk({tag, "_aluop"}, {28'd0, bus.ALUop}, {28'd0, op});
    chk({tag, "_alusrc"}, {31'd0, bus.ALUsrc}, {31'd0, src});
    step();
    chk({tag, "_wb_ruwr"}, {31'd0, bus.RUWr}, 32'd1);
    chk({tag, "_wb_aluop"}, {28'd0, bus.ALUop}, {28'd0, op});
    step();
    chk({tag, "_refetch"}, {31'd0, bus.imem_req}, 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    bus.instr    = 32'd0;
    #12;
    chk("rst_imem_req", {31'd0, bus.imem_req}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_halt", {31'd0, bus.halt}, 32'd0);
    chk("rst_aluop", {28'd0, bus.ALUop}, 32'd0);
`ifdef MULTICYCLE_PERF_CNT_EN
    chk("rst_retired", retired_cnt, 32'd0);
    chk("rst_cycles", cycle_cnt, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("idle_busy", {31'd0, bus.busy}, 32'd0);
    step();
    chk("fetch_req", {31'd0, bus.imem_req}, 32'd1);
    chk("fetch_busy", {31'd0, bus.busy}, 32'd1);

    // add with imem_ack one cycle late: WB is the 5th cycle from the first FETCH cycle
    do_fetch(InsAdd, 1);
    chk("add_dec_aluop", {28'd0, bus.ALUop}, 32'd0);
    chk("add_dec_req", {31'd0, bus.imem_req}, 32'd0);
    step();
    chk("add_exec_aluop", {28'd0, bus.ALUop}, 32'd0);
    chk("add_exec_ruwr", {31'd0, bus.RUWr}, 32'd0);
    step();
    chk("add_wb_ruwr", {31'd0, bus.RUWr}, 32'd1);
    chk("add_wb_pcwe", {31'd0, bus.pc_we}, 32'd1);
    chk("add_wb_req", {31'd0, bus.imem_req}, 32'd0);
    step();
    chk("add_next_pcwe", {31'd0, bus.pc_we}, 32'd0);
    chk("add_next_req", {31'd0, bus.imem_req}, 32'd1);
`ifdef MULTICYCLE_PERF_CNT_EN
    chk("add_retired", retired_cnt, 32'd1);
`endif

    run_alu("sub", InsSub, 4'b1000, 1'b0);
    run_alu("sra", InsSra, 4'b1101, 1'b0);
    run_alu("srai", InsSrai, 4'b1101, 1'b1);
    run_alu("andi", InsAndi, 4'b0111, 1'b1);

    // lw with dmem_ack after three waiting cycles
    do_fetch(InsLw, 0);
    step();
    chk("lw_exec_alusrc", {31'd0, bus.ALUsrc}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("lw_mem_req", {31'd0, bus.dmem_req}, 32'd1);
      chk("lw_mem_we", {31'd0, bus.dmem_we}, 32'd0);
    end
    step();
    bus.dmem_ack = 1'b1;
    #1;
    chk("lw_ack_req_drop", {31'd0, bus.dmem_req}, 32'd0);
    chk("lw_ack_pcwe", {31'd0, bus.pc_we}, 32'd0);
    step();
    bus.dmem_ack = 1'b0;
    chk("lw_wb_ruwr", {31'd0, bus.RUWr}, 32'd1);
    chk("lw_wb_pcwe", {31'd0, bus.pc_we}, 32'd1);
    step();
    chk("lw_refetch", {31'd0, bus.imem_req}, 32'd1);

    // sw: no RUWr, pc_we in the ack cycle
    do_fetch(InsSw, 0);
    step();
    step();
    chk("sw_mem_req", {31'd0, bus.dmem_req}, 32'd1);
    chk("sw_mem_we", {31'd0, bus.dmem_we}, 32'd1);
    chk("sw_mem_aluop", {28'd0, bus.ALUop}, 32'd0);
    step();
    bus.dmem_ack = 1'b1;
    #1;
    chk("sw_ack_pcwe", {31'd0, bus.pc_we}, 32'd1);
    chk("sw_ack_ruwr", {31'd0, bus.RUWr}, 32'd0);
    chk("sw_ack_req", {31'd0, bus.dmem_req}, 32'd0);
    step();
    bus.dmem_ack = 1'b0;
    chk("sw_refetch", {31'd0, bus.imem_req}, 32'd1);
    chk("sw_next_pcwe", {31'd0, bus.pc_we}, 32'd0);

    // illegal opcode -> sticky HALT, acks ignored
    do_fetch(InsIll, 0);
    step();
    chk("ill_halt", {31'd0, bus.halt}, 32'd1);
    chk("ill_busy", {31'd0, bus.busy}, 32'd0);
    bus.imem_ack = 1'b1;
    bus.dmem_ack = 1'b1;
    bus.instr    = InsAdd;
    step();
    step();
    chk("ill_hold_halt", {31'd0, bus.halt}, 32'd1);
    chk("ill_hold_req", {31'd0, bus.imem_req}, 32'd0);
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;

    do_reset();
    chk("rst_clears_halt", {31'd0, bus.halt}, 32'd0);
    do_fetch(InsMul, 0);
    step();
    chk("f7_ill_halt", {31'd0, bus.halt}, 32'd1);

    // fetch timeout: 16 cycles in FETCH then HALT
    do_reset();
    for (int i = 0; i < 15; i++) step();
    chk("to_c16_halt", {31'd0, bus.halt}, 32'd0);
    chk("to_c16_req", {31'd0, bus.imem_req}, 32'd1);
    step();
    chk("to_halt", {31'd0, bus.halt}, 32'd1);

    // ack in the 16th cycle wins over the timeout
    do_reset();
    do_fetch(InsSub, 15);
    chk("to_ack_halt", {31'd0, bus.halt}, 32'd0);
    chk("to_ack_busy", {31'd0, bus.busy}, 32'd1);
    step();
    chk("to_ack_exec", {28'd0, bus.ALUop}, 32'd8);

    // reset in the middle of MEM
    do_reset();
    do_fetch(InsLw, 0);
    step();
    step();
    chk("mrst_pre_req", {31'd0, bus.dmem_req}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_req_drop", {31'd0, bus.dmem_req}, 32'd0);
    chk("mrst_ruwr", {31'd0, bus.RUWr}, 32'd0);
    chk("mrst_busy", {31'd0, bus.busy}, 32'd0);
`ifdef MULTICYCLE_PERF_CNT_EN
    chk("mrst_retired", retired_cnt, 32'd0);
    chk("mrst_cycles", cycle_cnt, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("mrst_restart", {31'd0, bus.imem_req}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
